// File: rtl/dpll_ctrl.sv
// DPLL search controller: decide / check / backtrack over a literal stack.
// Optional DPLL_STATS_EN adds saturating decision and backtrack counters.
module dpll_ctrl #(
  parameter int VAR_W    = 3,
  parameter int NUM_VARS = 7
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  output logic                o_db_find,
  input  logic                i_db_done,
  input  logic                i_db_ended,
  input  logic [VAR_W:0]      i_db_lit,
  output logic                o_chk_start,
  input  logic                i_chk_done,
  input  logic                i_chk_conflict,
  output logic [NUM_VARS-1:0] o_assign_val,
  output logic [NUM_VARS-1:0] o_assign_set,
  output logic                o_busy,
  output logic                o_sat,
  output logic                o_unsat,
`ifdef DPLL_STATS_EN
  output logic [7:0]          o_n_decisions,
  output logic [7:0]          o_n_backtracks,
`endif
  output logic [2:0]          o_dbg_state
);

  localparam int SP_W = $clog2(NUM_VARS + 1);

  // Handshake: db_find is held for the whole DECIDE state and drops on the
  // edge that samples db_done; chk_start is a one-cycle pulse on CHECK entry.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DECIDE    = 3'd1,
    S_CHECK     = 3'd2,
    S_BACKTRACK = 3'd3,
    S_SAT       = 3'd4,
    S_UNSAT     = 3'd5
  } state_e;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [SP_W-1:0]       r_sp;
  logic [VAR_W-1:0]      r_stk_var  [NUM_VARS];
  logic                  r_stk_flip [NUM_VARS];
  logic [NUM_VARS-1:0]   r_assign_val;
  logic [NUM_VARS-1:0]   r_assign_set;
  logic                  r_chk_first;

  logic                  w_idle_like;
  logic                  w_start_acc;
  logic [VAR_W-1:0]      w_lit_var;
  logic                  w_lit_pol;
  logic [VAR_W-1:0]      w_lit_bit;
  logic                  w_push;
  logic [SP_W-1:0]       w_top_idx;
  logic [VAR_W-1:0]      w_top_bit;
  logic                  w_top_flip;
  logic                  w_bt_act;

  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_SAT) || (r_state == S_UNSAT);
  assign w_start_acc = i_start && w_idle_like;
  assign w_lit_var   = i_db_lit[VAR_W:1];
  assign w_lit_pol   = i_db_lit[0];
  assign w_lit_bit   = w_lit_var - 1'b1;
  assign w_push      = (r_state == S_DECIDE) && i_db_done && !i_db_ended &&
                       (w_lit_var != '0) && (r_sp < SP_W'(NUM_VARS));
  assign w_top_idx   = (r_sp == '0) ? '0 : r_sp - 1'b1;
  assign w_top_bit   = r_stk_var[w_top_idx] - 1'b1;
  assign w_top_flip  = r_stk_flip[w_top_idx];
  assign w_bt_act    = (r_state == S_BACKTRACK) && (r_sp != '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_db_find   = 1'b0;
    o_busy      = 1'b0;
    o_sat       = 1'b0;
    o_unsat     = 1'b0;
    case (r_state)
      S_IDLE: if (i_start) w_state_nxt = S_DECIDE;
      S_SAT: begin
        o_sat = 1'b1;
        if (i_start) w_state_nxt = S_DECIDE;
      end
      S_UNSAT: begin
        o_unsat = 1'b1;
        if (i_start) w_state_nxt = S_DECIDE;
      end
      S_DECIDE: begin
        o_db_find = 1'b1;
        o_busy    = 1'b1;
        if (i_db_done) w_state_nxt = w_push ? S_CHECK : S_SAT;
      end
      S_CHECK: begin
        o_busy = 1'b1;
        if (i_chk_done) w_state_nxt = i_chk_conflict ? S_BACKTRACK : S_DECIDE;
      end
      S_BACKTRACK: begin
        o_busy = 1'b1;
        if (r_sp == '0)      w_state_nxt = S_UNSAT;
        else if (!w_top_flip) w_state_nxt = S_CHECK;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sp         <= '0;
      r_assign_val <= '0;
      r_assign_set <= '0;
      r_chk_first  <= 1'b0;
      for (int i = 0; i < NUM_VARS; i++) begin
        r_stk_var[i]  <= '0;
        r_stk_flip[i] <= 1'b0;
      end
    end else begin
      r_chk_first <= (r_state != S_CHECK) && (w_state_nxt == S_CHECK);
      if (w_start_acc) begin
        r_sp         <= '0;
        r_assign_val <= '0;
        r_assign_set <= '0;
      end else if (w_push) begin
        r_stk_var[r_sp]         <= w_lit_var;
        r_stk_flip[r_sp]        <= 1'b0;
        r_assign_set[w_lit_bit] <= 1'b1;
        r_assign_val[w_lit_bit] <= w_lit_pol;
        r_sp                    <= r_sp + 1'b1;
      end else if (w_bt_act) begin
        // Flipped entry has exhausted both polarities: unwind it.
        if (w_top_flip) begin
          r_assign_set[w_top_bit] <= 1'b0;
          r_sp                    <= r_sp - 1'b1;
        end else begin
          r_assign_val[w_top_bit] <= ~r_assign_val[w_top_bit];
          r_stk_flip[w_top_idx]   <= 1'b1;
        end
      end
    end
  end

`ifdef DPLL_STATS_EN
  logic [7:0] r_n_dec;
  logic [7:0] r_n_bt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_n_dec <= '0;
      r_n_bt  <= '0;
    end else if (w_start_acc) begin
      r_n_dec <= '0;
      r_n_bt  <= '0;
    end else begin
      if (w_push && (r_n_dec != 8'hFF)) r_n_dec <= r_n_dec + 1'b1;
      if (w_bt_act && !w_top_flip && (r_n_bt != 8'hFF)) r_n_bt <= r_n_bt + 1'b1;
    end
  end

  assign o_n_decisions  = r_n_dec;
  assign o_n_backtracks = r_n_bt;
`endif

  assign o_chk_start  = (r_state == S_CHECK) && r_chk_first;
  assign o_assign_val = r_assign_val;
  assign o_assign_set = r_assign_set;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_dpll_ctrl.sv
// Directed bench for dpll_ctrl; build with DPLL_STATS_EN to also cover the counters.
module tb_dpll_ctrl;

  localparam logic [31:0] ST_IDLE = 0, ST_DECIDE = 1, ST_CHECK = 2,
                          ST_BT = 3, ST_SAT = 4, ST_UNSAT = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       db_find;
  logic       db_done = 1'b0;
  logic       db_ended = 1'b0;
  logic [3:0] db_lit = '0;
  logic       chk_start;
  logic       chk_done = 1'b0;
  logic       chk_conflict = 1'b0;
  logic [6:0] assign_val;
  logic [6:0] assign_set;
  logic       busy, sat, unsat;
  logic [2:0] dbg_state;
`ifdef DPLL_STATS_EN
  logic [7:0] n_dec, n_bt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  dpll_ctrl #(.VAR_W(3), .NUM_VARS(7)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .o_db_find      (db_find),
    .i_db_done      (db_done),
    .i_db_ended     (db_ended),
    .i_db_lit       (db_lit),
    .o_chk_start    (chk_start),
    .i_chk_done     (chk_done),
    .i_chk_conflict (chk_conflict),
    .o_assign_val   (assign_val),
    .o_assign_set   (assign_set),
    .o_busy         (busy),
    .o_sat          (sat),
    .o_unsat        (unsat),
`ifdef DPLL_STATS_EN
    .o_n_decisions  (n_dec),
    .o_n_backtracks (n_bt),
`endif
    .o_dbg_state    (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change and outputs are sampled 1 time unit after posedge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input string tag, input logic [31:0] s);
    int n = 0;
    while ((32'(dbg_state) != s) && (n < 20)) begin
      tick();
      n++;
    end
    check(tag, 32'(dbg_state), s);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic decide(input logic ended, input logic [2:0] v, input logic pol);
    wait_state("wait_decide", ST_DECIDE);
    db_done  = 1'b1;
    db_ended = ended;
    db_lit   = {v, pol};
    tick();
    db_done  = 1'b0;
    db_ended = 1'b0;
  endtask

  task automatic check_resp(input logic conflict);
    wait_state("wait_check", ST_CHECK);
    chk_done     = 1'b1;
    chk_conflict = conflict;
    tick();
    chk_done     = 1'b0;
    chk_conflict = 1'b0;
  endtask

  initial begin
    // reset state
    #22;
    check("rst_state", 32'(dbg_state), ST_IDLE);
    check("rst_outs", {busy, sat, unsat, db_find, chk_start}, 0);
    check("rst_assign", {assign_set, assign_val}, 0);
    rst_n = 1'b1;
    tick(); tick(); tick();
    check("idle_hold", 32'(dbg_state), ST_IDLE);

    // single decision then ended -> sat
    do_start();
    check("t1_decide", 32'(dbg_state), ST_DECIDE);
    check("t1_find_busy", {db_find, busy}, 2'b11);
    decide(1'b0, 3'd5, 1'b1);
    check("t1_check_entry", {32'(dbg_state)}, ST_CHECK);
    check("t1_chk_start", {chk_start, db_find}, 2'b10);
    check("t1_set", assign_set, 7'b0010000);
    check_resp(1'b0);
    check("t1_back_decide", 32'(dbg_state), ST_DECIDE);
    decide(1'b1, 3'd0, 1'b0);
    check("t1_sat", {sat, unsat, busy}, 3'b100);
    check("t1_set_val", {assign_set, assign_val}, {7'b0010000, 7'b0010000});
`ifdef DPLL_STATS_EN
    check("t1_ndec", n_dec, 1);
`endif

    // flip of var2 after conflict
    do_start();
    check("t2_cleared", {sat, assign_set}, 0);
    decide(1'b0, 3'd1, 1'b1);
    check_resp(1'b0);
    decide(1'b0, 3'd2, 1'b0);
    check("t2_val_pre", assign_val, 7'b0000001);
    check_resp(1'b1);
    check("t2_bt", 32'(dbg_state), ST_BT);
    tick();
    check("t2_flip_state", 32'(dbg_state), ST_CHECK);
    check("t2_flip_val", {assign_set, assign_val}, {7'b0000011, 7'b0000011});
    check("t2_chk_pulse", chk_start, 1'b1);
    tick();
    check("t2_chk_once", {chk_start, 32'(dbg_state)}, {1'b0, ST_CHECK});
    check_resp(1'b0);
    decide(1'b1, 3'd0, 1'b0);
    check("t2_sat", {sat, unsat}, 2'b10);
`ifdef DPLL_STATS_EN
    check("t2_nbt", n_bt, 1);
`endif

    // flip, conflict again, pop, unsat
    do_start();
    decide(1'b0, 3'd1, 1'b1);
    check_resp(1'b1);
    tick();
    check("t3_flip", {32'(dbg_state), assign_val[0]}, {ST_CHECK, 1'b0});
    check_resp(1'b1);
    tick();
    check("t3_pop", {32'(dbg_state), assign_set}, {ST_BT, 7'b0});
    tick();
    check("t3_unsat", {unsat, sat, busy, assign_set}, {3'b100, 7'b0});

    // spurious db_done in CHECK, start in DECIDE, simultaneous dones
    do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_start_ign", {32'(dbg_state), assign_set}, {ST_DECIDE, 7'b0});
    db_done = 1'b1; db_lit = {3'd4, 1'b1};
    chk_done = 1'b1; chk_conflict = 1'b1;
    tick();
    db_done = 1'b0; chk_done = 1'b0; chk_conflict = 1'b0;
    check("t4_both_done", {32'(dbg_state), assign_set}, {ST_CHECK, 7'b0001000});
    db_done = 1'b1; db_lit = {3'd6, 1'b1};
    tick();
    db_done = 1'b0;
    check("t4_db_ign", {32'(dbg_state), assign_set}, {ST_CHECK, 7'b0001000});
    check_resp(1'b0);
    decide(1'b1, 3'd0, 1'b0);
    check("t4_sat", sat, 1'b1);

    // null literal -> sat without push
    do_start();
    decide(1'b0, 3'd0, 1'b1);
    check("t5_null", {sat, assign_set}, {1'b1, 7'b0});

    // stack full
    do_start();
    for (int v = 1; v <= 7; v++) begin
      decide(1'b0, 3'(v), 1'(v % 2));
      check_resp(1'b0);
    end
    decide(1'b0, 3'd3, 1'b1);
    check("t6_full", {sat, assign_set, assign_val}, {1'b1, 7'h7F, 7'h55});
`ifdef DPLL_STATS_EN
    check("t6_ndec", n_dec, 7);
`endif

    // async reset mid-CHECK
    do_start();
    decide(1'b0, 3'd1, 1'b1);
    check_resp(1'b0);
    decide(1'b0, 3'd2, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t7_rst_now", {busy, sat, unsat, db_find, chk_start, assign_set, assign_val}, 0);
    check("t7_rst_state", 32'(dbg_state), ST_IDLE);
    #3 rst_n = 1'b1;
    tick(); tick();
    check("t7_idle", 32'(dbg_state), ST_IDLE);
    do_start();
    decide(1'b1, 3'd0, 1'b0);
    check("t7_resume", sat, 1'b1);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
